data_dechunking: RTL

Reassembles a stream of OUTPUT_LEN-wide chunks back into INPUT_LEN-wide words. It is the receive-side counterpart of the chunking stage: it sits where serialized byte streams re-enter the neuromorphic processor, for example spike/event packets arriving over a narrow link. Chunks arrive MSB-first on consecutive cycles, qualified by a valid flag. A gap inside a word discards the partial word and flags a framing error.

---
 rtl/data_dechunking_if.sv | 33 +++
 rtl/data_dechunking.sv | 77 +++++++
 2 files changed

// File: rtl/data_dechunking_if.sv
// data_dechunking_if
// Bundles the chunk input and word output signals of the dechunker.
//   slave  : the dechunker side (takes chunks, drives the word, status and error outputs)
//   master : the chunk source / observer side
// Signals:
//   in_val, data_in   : incoming chunk and its qualifier
//   out_val, data_out : completion pulse and last completed word
//   busy              : partial word in progress
//   frame_err         : pulse when a partial word is discarded
//   err_cnt           : saturating count of discarded partial words
interface data_dechunking_if #(
    parameter int INPUT_LEN  = 24,
    parameter int OUTPUT_LEN = 8,
    parameter int ERR_CNT_W  = 8
);
    logic                  in_val;
    logic [OUTPUT_LEN-1:0] data_in;
    logic                  out_val;
    logic [INPUT_LEN-1:0]  data_out;
    logic                  busy;
    logic                  frame_err;
    logic [ERR_CNT_W-1:0]  err_cnt;

    modport slave (
        input  in_val, data_in,
        output out_val, data_out, busy, frame_err, err_cnt
    );

    modport master (
        output in_val, data_in,
        input  out_val, data_out, busy, frame_err, err_cnt
    );
endinterface

// File: rtl/data_dechunking.sv
// data_dechunking
// Reassembles MSB-first OUTPUT_LEN-wide chunks into INPUT_LEN-wide words.
// A cycle without a valid chunk in the middle of a word discards the
// partial word, pulses frame_err and bumps a saturating error counter.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : data_dechunking_if slave modport (chunk in, word/status out)
module data_dechunking #(
    parameter int INPUT_LEN  = 24,
    parameter int OUTPUT_LEN = 8,
    parameter int ERR_CNT_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    data_dechunking_if.slave   bus
);
    localparam int N     = INPUT_LEN / OUTPUT_LEN;
    localparam int CNT_W = (N > 2) ? $clog2(N) : 1;
    localparam int PW    = (N - 1) * OUTPUT_LEN;

    logic [CNT_W-1:0]      r_cnt;
    logic [PW-1:0]         r_part;
    logic [INPUT_LEN-1:0]  r_data_out;
    logic                  r_out_val;
    logic                  r_frame_err;
    logic                  r_busy;
    logic [ERR_CNT_W-1:0]  r_err_cnt;

    logic [INPUT_LEN-1:0]  w_word;
    logic                  w_last;

    // Partial register concatenated with the current chunk; its low PW bits
    // are the shifted partial, the full width is the completed word.
    assign w_word = {r_part, bus.data_in};
    assign w_last = (r_cnt == CNT_W'(N - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt       <= '0;
            r_part      <= '0;
            r_data_out  <= '0;
            r_out_val   <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_out_val   <= 1'b0;
            r_frame_err <= 1'b0;
            if (bus.in_val) begin
                if (w_last) begin
                    r_data_out <= w_word;
                    r_out_val  <= 1'b1;
                    r_cnt      <= '0;
                    r_busy     <= 1'b0;
                end else begin
                    r_part <= w_word[PW-1:0];
                    r_cnt  <= r_cnt + CNT_W'(1);
                    r_busy <= 1'b1;
                end
            end else if (r_cnt != '0) begin
                r_cnt       <= '0;
                r_busy      <= 1'b0;
                r_frame_err <= 1'b1;
                if (r_err_cnt != '1) begin
                    r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
                end
            end
        end
    end

    assign bus.out_val   = r_out_val;
    assign bus.data_out  = r_data_out;
    assign bus.busy      = r_busy;
    assign bus.frame_err = r_frame_err;
    assign bus.err_cnt   = r_err_cnt;
endmodule
